// File: rtl/multdiv_pkg.sv
// Shared widths, FSM state encoding and radix-4 Booth recode constants
// for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int WORD_W    = 32;
    localparam int PP_W      = WORD_W + 2;
    localparam int ACC_W     = PP_W + WORD_W;
    localparam int CNT_W     = 6;
    localparam int MUL_ITERS = 16;
    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PA,
        P2A,
        NA,
        N2A
    } booth_e;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_e booth_code(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: return PA;
            3'b011:         return P2A;
            3'b100:         return N2A;
            3'b101, 3'b110: return NA;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/multdiv_booth_recode.sv
// Combinational radix-4 Booth partial-product generator: maps a 3-bit
// multiplier window to 0, +/-A or +/-2A, sign-extended to PP_W bits.
module booth_recode
    import multdiv_pkg::*;
(
    input  logic [2:0]        win_i,
    input  logic [WORD_W-1:0] a_i,
    output logic [PP_W-1:0]   pp_o
);

    logic [PP_W-1:0] a_ext;
    assign a_ext = {{(PP_W-WORD_W){a_i[WORD_W-1]}}, a_i};

    always_comb begin
        pp_o = '0;
        case (booth_code(win_i))
            PA:      pp_o = a_ext;
            P2A:     pp_o = a_ext << 1;
            NA:      pp_o = -a_ext;
            N2A:     pp_o = -(a_ext << 1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth, 16 steps) and divide
// (restoring on magnitudes, 32 steps) with a one-cycle fix-up stage.
module multdiv
    import multdiv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [WORD_W-1:0] data_operandA,
    input  logic [WORD_W-1:0] data_operandB,
    output logic [WORD_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic                qm1_q;
    logic [WORD_W-1:0]   mcand_q;
    logic [WORD_W-1:0]   dvs_q;
    logic                neg_q;
    logic                dz_q;
    logic                op_mul_q;
    logic [WORD_W-1:0]   result_q;
    logic                exc_q;
    logic                rdy_q;
    logic                busy_q;

    // acc_q holds {hi, lo}: product high/low for multiply,
    // {remainder, quotient} for divide.
    logic [PP_W-1:0]   hi;
    logic [WORD_W-1:0] lo;
    assign hi = acc_q[ACC_W-1:WORD_W];
    assign lo = acc_q[WORD_W-1:0];

    logic [PP_W-1:0] pp;
    booth_recode u_booth (
        .win_i ({lo[1:0], qm1_q}),
        .a_i   (mcand_q),
        .pp_o  (pp)
    );

    logic [PP_W-1:0]  mul_sum;
    logic [ACC_W-1:0] mul_next;
    assign mul_sum  = hi + pp;
    assign mul_next = {{2{mul_sum[PP_W-1]}}, mul_sum, lo[WORD_W-1:2]};

    logic [WORD_W:0]   rem_sh;
    logic [PP_W-1:0]   div_diff;
    logic [ACC_W-1:0]  div_next;
    assign rem_sh   = {hi[WORD_W-1:0], lo[WORD_W-1]};
    assign div_diff = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign div_next = div_diff[PP_W-1]
                    ? {1'b0, rem_sh,              lo[WORD_W-2:0], 1'b0}
                    : {1'b0, div_diff[WORD_W:0],  lo[WORD_W-2:0], 1'b1};

    logic [WORD_W-1:0] a_mag, b_mag;
    assign a_mag = data_operandA[WORD_W-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WORD_W-1] ? -data_operandB : data_operandB;

    logic mul_ovf;
    assign mul_ovf = hi[WORD_W-1:0] != {WORD_W{lo[WORD_W-1]}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            mcand_q  <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            op_mul_q <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (ctrl_MULT) begin
                        state_q  <= MUL;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= {{PP_W{1'b0}}, data_operandB};
                        qm1_q    <= 1'b0;
                        mcand_q  <= data_operandA;
                        op_mul_q <= 1'b1;
                    end else if (ctrl_DIV) begin
                        state_q  <= DIV;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= {{PP_W{1'b0}}, a_mag};
                        dvs_q    <= b_mag;
                        neg_q    <= data_operandA[WORD_W-1] ^ data_operandB[WORD_W-1];
                        dz_q     <= data_operandB == '0;
                        op_mul_q <= 1'b0;
                    end
                end
                MUL: begin
                    acc_q <= mul_next;
                    qm1_q <= lo[1];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MUL_ITERS - 1))
                        state_q <= FIX;
                end
                DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_ITERS - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                    if (op_mul_q) begin
                        result_q <= lo;
                        exc_q    <= mul_ovf;
                    end else if (dz_q) begin
                        result_q <= '0;
                        exc_q    <= 1'b1;
                    end else begin
                        // Negating the magnitude of 0x80000000 wraps to itself.
                        result_q <= neg_q ? -lo : lo;
                        exc_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv.sv
// Directed-vector bench for multdiv: latency, result/exception, busy,
// start-ignore/priority rules and asynchronous reset.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Caller sets up timing so that the next rising edge is edge 0.
    // inj > 0 pulses ctrl_MULT so that edge inj samples it.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] res, input logic exc,
                          input int inj, input bit tail);
        int k;
        bit bsy_ok;
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        k = 0;
        bsy_ok = 1'b1;
        while (!data_resultRDY && k < 40) begin
            if (!busy) bsy_ok = 1'b0;
            ctrl_MULT = (k == inj - 1);
            @(posedge clock);
            #1;
            ctrl_MULT = 1'b0;
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " result"}, data_result, res);
        chk({tag, " exception"}, {31'b0, data_exception}, {31'b0, exc});
        chk({tag, " busy while running"}, {31'b0, bsy_ok}, 32'd1);
        chk({tag, " busy at ready"}, {31'b0, busy}, 32'd0);
        if (tail) begin
            @(posedge clock);
            #1;
            chk({tag, " ready one cycle"}, {31'b0, data_resultRDY}, 32'd0);
            @(negedge clock);
        end
    endtask

    initial begin
        int nrdy;
        #1 reset = 1'b1;
        #2;
        chk("reset result", data_result, 32'h0);
        chk("reset exception", {31'b0, data_exception}, 32'd0);
        chk("reset ready", {31'b0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_op("7*-6",        1, 0, 32'h00000007, 32'hFFFFFFFA, 17, 32'hFFFFFFD6, 0, 0, 1);
        run_op("-3*-5",       1, 0, 32'hFFFFFFFD, 32'hFFFFFFFB, 17, 32'h0000000F, 0, 0, 1);
        run_op("2^16*2^16",   1, 0, 32'h00010000, 32'h00010000, 17, 32'h00000000, 1, 0, 1);
        run_op("min*1",       1, 0, 32'h80000000, 32'h00000001, 17, 32'h80000000, 0, 0, 1);
        run_op("-100/7",      0, 1, 32'hFFFFFF9C, 32'h00000007, 33, 32'hFFFFFFF2, 0, 0, 1);
        run_op("100/-7",      0, 1, 32'h00000064, 32'hFFFFFFF9, 33, 32'hFFFFFFF2, 0, 0, 1);
        run_op("5/0",         0, 1, 32'h00000005, 32'h00000000, 33, 32'h00000000, 1, 0, 1);
        run_op("min/-1",      0, 1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 0, 0, 1);
        run_op("div ign mul", 0, 1, 32'h000003E8, 32'hFFFFFFF6, 33, 32'hFFFFFF9C, 0, 5, 1);
        // Both starts together; finish in the DONE cycle to chain a divide.
        run_op("mul+div",     1, 1, 32'h00000003, 32'h00000004, 17, 32'h0000000C, 0, 0, 0);
        run_op("div in DONE", 0, 1, 32'h0000002D, 32'h00000007, 33, 32'h00000006, 0, 0, 1);
        run_op("max*2",       1, 0, 32'h7FFFFFFF, 32'h00000002, 17, 32'hFFFFFFFE, 1, 0, 1);

        // Asynchronous reset mid-multiply.
        ctrl_MULT = 1'b1;
        data_operandA = 32'h00000005;
        data_operandB = 32'h00000007;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        repeat (8) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("async rst result", data_result, 32'h0);
        chk("async rst exception", {31'b0, data_exception}, 32'd0);
        chk("async rst ready", {31'b0, data_resultRDY}, 32'd0);
        chk("async rst busy", {31'b0, busy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        nrdy = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (data_resultRDY || busy) nrdy++;
        end
        chk("no ready after reset", 32'(nrdy), 32'd0);
        @(negedge clock);
        run_op("2*3 after rst", 1, 0, 32'h00000002, 32'h00000003, 17, 32'h00000006, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
